// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit; latches one access, runs a valid/ready bus request, returns aligned load data.
// Build option: define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of silently aligning them.
//
// state | meaning
// IDLE  | no access in flight; latches the access on go
// REQ   | dbus_req_valid high, fields held until the handshake
// WAIT  | request accepted, waiting for a response or timeout
// DONE  | one-cycle completion pulse, pipeline advances
module mem_lsu #(
    parameter int TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_mem_ena,
    input  logic        mem_mem_wen,
    input  logic [3:0]  mem_mem_mask,
    input  logic [63:0] mem_alu_result,
    input  logic [63:0] mem_rf_rdata2,
    output logic        lsu_stall,
    output logic        lsu_done,
    output logic [63:0] lsu_rdata,
    output logic        lsu_fault,
    output logic        lsu_misalign,
    output logic        dbus_req_valid,
    input  logic        dbus_req_ready,
    output logic [63:0] dbus_req_addr,
    output logic        dbus_req_wen,
    output logic [7:0]  dbus_req_wstrb,
    output logic [63:0] dbus_req_wdata,
    input  logic        dbus_rsp_valid,
    input  logic [63:0] dbus_rsp_rdata,
    input  logic        dbus_rsp_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0]   addr_q, addr_d;
    logic [1:0]    size_q, size_d;
    logic          ext_q, ext_d;
    logic          wen_q, wen_d;
    logic [63:0]   wdata_q, wdata_d;
    logic [63:0]   rdata_q, rdata_d;
    logic          fault_q, fault_d;
`ifdef LSU_MISALIGN_TRAP_EN
    logic          misalign_q, misalign_d;
    logic          misaligned;
`endif

    logic        go;
    logic [2:0]  low_mask;
    logic [63:0] addr_in;
    logic [63:0] rsp_shift;
    logic [63:0] load_data;
    logic [7:0]  strb_base;
    logic [63:0] wdata_rep;
    logic        req_active;
    logic        done_active;
    logic        unused_mask3;

    assign unused_mask3 = mem_mem_mask[3];
    assign go = mem_valid & mem_mem_ena;

    always_comb begin
        case (mem_mem_mask[1:0])
            2'b00:   low_mask = 3'b000;
            2'b01:   low_mask = 3'b001;
            2'b10:   low_mask = 3'b011;
            default: low_mask = 3'b111;
        endcase
    end

    // Address bits below the access size are always cleared; in the trap build a
    // misaligned access never reaches the bus, so the cleared copy is never used there.
    assign addr_in = {mem_alu_result[63:3], mem_alu_result[2:0] & ~low_mask};
`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = |(mem_alu_result[2:0] & low_mask);
`endif

    assign rsp_shift = dbus_rsp_rdata >> {addr_q[2:0], 3'b000};

    always_comb begin
        case (size_q)
            2'b00:   load_data = {{56{~ext_q & rsp_shift[7]}},  rsp_shift[7:0]};
            2'b01:   load_data = {{48{~ext_q & rsp_shift[15]}}, rsp_shift[15:0]};
            2'b10:   load_data = {{32{~ext_q & rsp_shift[31]}}, rsp_shift[31:0]};
            default: load_data = rsp_shift;
        endcase
    end

    always_comb begin
        case (size_q)
            2'b00: begin
                strb_base = 8'h01;
                wdata_rep = {8{wdata_q[7:0]}};
            end
            2'b01: begin
                strb_base = 8'h03;
                wdata_rep = {4{wdata_q[15:0]}};
            end
            2'b10: begin
                strb_base = 8'h0F;
                wdata_rep = {2{wdata_q[31:0]}};
            end
            default: begin
                strb_base = 8'hFF;
                wdata_rep = wdata_q;
            end
        endcase
    end

    assign req_active  = (state_q == S_REQ);
    assign done_active = (state_q == S_DONE);

    assign dbus_req_valid = req_active;
    assign dbus_req_addr  = req_active ? {addr_q[63:3], 3'b000} : 64'd0;
    assign dbus_req_wen   = req_active & wen_q;
    assign dbus_req_wstrb = req_active ? (strb_base << addr_q[2:0]) : 8'd0;
    assign dbus_req_wdata = req_active ? wdata_rep : 64'd0;

    // Stall is gated by rst so every output reads 0 while reset is held.
    assign lsu_stall = ~rst & (((state_q == S_IDLE) & go) | req_active | (state_q == S_WAIT));
    assign lsu_done  = done_active;
    assign lsu_rdata = done_active ? rdata_q : 64'd0;
    assign lsu_fault = done_active & fault_q;
`ifdef LSU_MISALIGN_TRAP_EN
    assign lsu_misalign = done_active & misalign_q;
`else
    assign lsu_misalign = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        size_d  = size_q;
        ext_d   = ext_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    addr_d  = addr_in;
                    size_d  = mem_mem_mask[1:0];
                    ext_d   = mem_mem_mask[2];
                    wen_d   = mem_mem_wen;
                    wdata_d = mem_rf_rdata2;
                    rdata_d = 64'd0;
                    fault_d = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
                    misalign_d = misaligned;
                    state_d    = misaligned ? S_DONE : S_REQ;
`else
                    state_d = S_REQ;
`endif
                end
            end
            S_REQ: begin
                if (dbus_req_ready) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            S_WAIT: begin
                if (dbus_rsp_valid) begin
                    state_d = S_DONE;
                    fault_d = dbus_rsp_err;
                    rdata_d = (dbus_rsp_err | wen_q) ? 64'd0 : load_data;
                end else if ((TIMEOUT != 0) && (cnt_q == '0)) begin
                    state_d = S_DONE;
                    fault_d = 1'b1;
                    rdata_d = 64'd0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= 64'd0;
            size_q  <= 2'd0;
            ext_q   <= 1'b0;
            wen_q   <= 1'b0;
            wdata_q <= 64'd0;
            rdata_q <= 64'd0;
            fault_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            ext_q   <= ext_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end

endmodule
